// File: rtl/serial_rho_stream_pkg.sv
// Shared definitions for the column-serial rho layer: FSM encoding,
// default sizing and an index-width helper.
package serial_rho_stream_pkg;

  // LOAD collects columns, EMIT streams the transformed columns out.
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } rho_state_e;

  localparam int DEF_BLOCK_SIZE = 64;
  localparam int DEF_NUM_COLS   = 4;

  // Width of a column index; at least one bit so a 2-column build still has a counter.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_rho_stream_colbuf.sv
// Column buffer: NUM_COLS x COLUMN_SIZE storage, one write port and one
// asynchronous read port sharing the same index. Storage is not reset;
// every entry is rewritten before it is read.
module serial_rho_stream_colbuf #(
  parameter int NUM_COLS    = 4,
  parameter int COLUMN_SIZE = 8,
  parameter int IDX_W       = 2
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic [COLUMN_SIZE-1:0] i_wdata,
  output logic [COLUMN_SIZE-1:0] o_rdata
);

  logic [COLUMN_SIZE-1:0] r_mem [NUM_COLS];

  // Capture an accepted input column at the current index.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/serial_rho_stream.sv
// Column-serial rho layer. Loads one half-state column by column while
// accumulating the XOR of all columns, then emits y[k] = acc ^ a[k].
// For even NUM_COLS the map is its own inverse.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in LOAD, out_valid only in EMIT; once
// out_valid is high, out_data/out_last hold until the transfer, and in_data
// is ignored whenever in_ready is low. Both are forced low while rst is high.
module serial_rho_stream
  import serial_rho_stream_pkg::*;
#(
  parameter int BLOCK_SIZE  = DEF_BLOCK_SIZE,
  parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
  parameter int NUM_COLS    = DEF_NUM_COLS,
  parameter int COLUMN_SIZE = SIDE_SIZE / NUM_COLS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COLUMN_SIZE-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLUMN_SIZE-1:0] out_data,
  output logic                   out_last,
  output logic                   dbg_state
);

  localparam int                 IDX_W    = idx_width(NUM_COLS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_COLS - 1);

  // Reject geometries where columns do not tile the half-state or the map is not an involution.
  if (((SIDE_SIZE % NUM_COLS) != 0) || ((NUM_COLS % 2) != 0) || (NUM_COLS < 2)) begin : g_bad_params
    $error("serial_rho_stream: NUM_COLS must be even, >=2 and divide SIDE_SIZE");
  end

  rho_state_e             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [COLUMN_SIZE-1:0] r_acc;

  logic                   w_in_fire;
  logic                   w_out_fire;
  logic [COLUMN_SIZE-1:0] w_rd_data;

  assign in_ready   = ~rst & (r_state == ST_LOAD);
  assign out_valid  = ~rst & (r_state == ST_EMIT);
  assign out_last   = out_valid & (r_idx == LAST_IDX);
  assign out_data   = w_rd_data ^ r_acc;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign dbg_state  = r_state;

  serial_rho_stream_colbuf #(
    .NUM_COLS    (NUM_COLS),
    .COLUMN_SIZE (COLUMN_SIZE),
    .IDX_W       (IDX_W)
  ) u_colbuf (
    .clk     (clk),
    .i_we    (w_in_fire),
    .i_idx   (r_idx),
    .i_wdata (in_data),
    .o_rdata (w_rd_data)
  );

  // FSM, column index and running XOR; the index wraps to 0 at the end of each phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_idx   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            r_acc <= r_acc ^ in_data;
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= ST_EMIT;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_EMIT: begin
          if (w_out_fire) begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_acc   <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rho_stream.sv
// Bench for serial_rho_stream (BLOCK_SIZE=64, NUM_COLS=4, 8-bit columns).
module tb_serial_rho_stream;

  typedef logic [7:0] col_t;
  typedef col_t half_t [4];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  col_t in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  col_t out_data;
  logic out_last;
  logic dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [8:0] exp_q[$];

  serial_rho_stream #(
    .BLOCK_SIZE (64),
    .NUM_COLS   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a transfer happens on the next rising edge
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    if (!rst && out_valid) check("emit_in_ready_low", {15'd0, in_ready}, 16'd0);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got last=%0b data=%0h expected no output", out_last, out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_col", {7'd0, out_last, out_data}, {7'd0, e});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_col(input col_t d);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_col_timeout: in_ready=0 required 1");
    end
    tick();
    in_valid = 1'b0;
    in_data  = col_t'($urandom);
  endtask

  task automatic send_half(input half_t a);
    for (int i = 0; i < 4; i++) send_col(a[i]);
  endtask

  task automatic expect_half(input half_t e);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, e[i]});
  endtask

  task automatic drain(input bit rand_ready);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      guard++;
    end
    out_ready = 1'b1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d columns outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic half_t rho_model(input half_t a);
    half_t r;
    col_t  s;
    s = a[0] ^ a[1] ^ a[2] ^ a[3];
    for (int i = 0; i < 4; i++) r[i] = s ^ a[i];
    return r;
  endfunction

  half_t t1_in, t1_exp, t2_in, t2_exp, t5_in, t5_exp, t6_in, t6_exp, t7_in, t7_exp, rnd;
  bit    pat [7];
  int    c0;
  int    k;

  initial begin
    t1_in  = '{8'h01, 8'h02, 8'h04, 8'h08};
    t1_exp = '{8'h0E, 8'h0D, 8'h0B, 8'h07};
    t2_in  = '{8'h0E, 8'h0D, 8'h0B, 8'h07};
    t2_exp = '{8'h01, 8'h02, 8'h04, 8'h08};
    t5_in  = '{8'hFF, 8'h00, 8'h00, 8'h00};
    t5_exp = '{8'h00, 8'hFF, 8'hFF, 8'hFF};
    t6_in  = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
    t6_exp = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
    t7_in  = '{8'h12, 8'h34, 8'h56, 8'h78};
    t7_exp = '{8'h1A, 8'h3C, 8'h5E, 8'h70};
    pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", {15'd0, in_ready}, 16'd0);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_last", {15'd0, out_last}, 16'd0);
    check("rst_state", {15'd0, dbg_state}, 16'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", {15'd0, in_ready}, 16'd1);

    // T1 basic pattern and first-output latency
    expect_half(t1_exp);
    for (int i = 0; i < 3; i++) send_col(t1_in[i]);
    check("t1_no_early_valid", {15'd0, out_valid}, 16'd0);
    send_col(t1_in[3]);
    check("t1_latency_valid", {15'd0, out_valid}, 16'd1);
    drain(1'b0);

    // T2 involution of T1 output
    expect_half(t2_exp);
    send_half(t2_in);
    drain(1'b0);

    // T3 backpressure on column 2
    out_ready = 1'b0;
    expect_half(t1_exp);
    send_half(t1_in);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_data", {8'd0, out_data}, 16'h000B);
      check("t3_hold_valid", {15'd0, out_valid}, 16'd1);
      check("t3_hold_last", {15'd0, out_last}, 16'd0);
      check("t3_in_ready", {15'd0, in_ready}, 16'd0);
      tick();
    end
    in_valid = 1'b0;
    drain(1'b0);

    // T4 input bubbles
    expect_half(t1_exp);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin
        send_col(t1_in[k]);
        k++;
      end else begin
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_in_ready_bubble", {15'd0, in_ready}, 16'd1);
        tick();
      end
    end
    drain(1'b0);

    // T5 reset mid-LOAD
    send_col(8'h33);
    send_col(8'h44);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_in_ready", {15'd0, in_ready}, 16'd0);
    check("t5_rst_out_valid", {15'd0, out_valid}, 16'd0);
    tick();
    tick();
    rst = 1'b0;
    expect_half(t5_exp);
    send_half(t5_in);
    drain(1'b0);

    // reset mid-EMIT, then a self-inverse pattern
    out_ready = 1'b0;
    send_half(t7_in);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_emit_out_valid", {15'd0, out_valid}, 16'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    expect_half(t6_exp);
    send_half(t6_in);
    drain(1'b0);

    // ordinary directed pattern
    expect_half(t7_exp);
    send_half(t7_in);
    drain(1'b0);

    // back-to-back throughput: 2*NUM_COLS cycles per half-state
    c0 = cyc;
    for (int h = 0; h < 4; h++) begin
      for (int i = 0; i < 4; i++) rnd[i] = col_t'($urandom_range(0, 255));
      expect_half(rho_model(rnd));
      send_half(rnd);
      drain(1'b0);
    end
    check("throughput_cycles", 16'(cyc - c0), 16'd32);

    // random half-states against the model, with random backpressure and involution check
    for (int h = 0; h < 20; h++) begin
      for (int i = 0; i < 4; i++) rnd[i] = col_t'($urandom_range(0, 255));
      expect_half(rho_model(rnd));
      send_half(rnd);
      drain(1'b1);
      expect_half(rnd);
      send_half(rho_model(rnd));
      drain(1'b1);
    end

    check("final_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
